axis_frame_arbiter: RTL



---
 rtl/axis_frame_arbiter_if.sv | 14 +
 rtl/axis_frame_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/axis_frame_arbiter_if.sv
// rtl/axis_frame_arbiter_if.sv - stream bundle carrying LANES parallel sample lanes plus a source tag
interface axis_frame_arbiter_if #(
    parameter int LANES = 1,
    parameter int ID_W  = 1
);
    logic [LANES-1:0][63:0] tdata;
    logic [LANES-1:0]       tlast;
    logic [LANES-1:0]       tvalid;
    logic [LANES-1:0]       tready;
    logic [ID_W-1:0]        tid;

    modport master (output tdata, output tlast, output tvalid, output tid, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_frame_arbiter.sv
// rtl/axis_frame_arbiter.sv - frame-granular round-robin arbiter feeding one FFT sample stream
module axis_frame_arbiter #(
    parameter int N_PORTS   = 4,
    parameter int FRAME_LEN = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    axis_frame_arbiter_if.slave  s_axis,
    axis_frame_arbiter_if.master m_axis,
    output logic [N_PORTS-1:0]   err_len,
    input  logic                 err_clr,
    output logic                 busy
);
    localparam int ID_W  = $clog2(N_PORTS);
    localparam int CNT_W = $clog2(FRAME_LEN);

    typedef enum logic {
        IDLE,
        PASS
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_last_q, rr_last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [63:0]        m_tdata_q, m_tdata_d;
    logic [ID_W-1:0]    m_tid_q, m_tid_d;
    logic               m_tlast_q, m_tlast_d;
    logic               m_tvalid_q, m_tvalid_d;
    logic [N_PORTS-1:0] err_q, err_d;

    logic [ID_W-1:0]    scan_idx;
    logic [ID_W-1:0]    pick;
    logic               found;
    logic               at_last;
    logic               out_free;
    logic               take;

    // Round-robin search starting just after the last granted port, with wrap.
    always_comb begin
        scan_idx = '0;
        pick     = rr_last_q;
        found    = 1'b0;
        for (int i = 1; i <= N_PORTS; i++) begin
            scan_idx = ID_W'((int'(rr_last_q) + i) % N_PORTS);
            if (!found && s_axis.tvalid[scan_idx]) begin
                found = 1'b1;
                pick  = scan_idx;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_last_d     = rr_last_q;
        cnt_d         = cnt_q;
        m_tdata_d     = m_tdata_q;
        m_tid_d       = m_tid_q;
        m_tlast_d     = m_tlast_q;
        m_tvalid_d    = m_tvalid_q;
        err_d         = err_q;
        s_axis.tready = '0;
        take          = 1'b0;
        at_last       = (cnt_q == CNT_W'(FRAME_LEN - 1));
        out_free      = !m_tvalid_q || m_axis.tready[0];

        if (err_clr) begin
            err_d = '0;
        end
        if (m_axis.tready[0]) begin
            m_tvalid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d   = PASS;
                    rr_last_d = pick;
                    cnt_d     = '0;
                end
            end
            PASS: begin
                if (out_free) begin
                    s_axis.tready[rr_last_q] = 1'b1;
                    take = s_axis.tvalid[rr_last_q];
                end
            end
            default: state_d = IDLE;
        endcase

        // Frame end is decided by the beat count alone; upstream tlast only feeds the error flag.
        if (take) begin
            m_tdata_d  = s_axis.tdata[rr_last_q];
            m_tid_d    = rr_last_q;
            m_tlast_d  = at_last;
            m_tvalid_d = 1'b1;
            cnt_d      = cnt_q + CNT_W'(1);
            if (s_axis.tlast[rr_last_q] != at_last) begin
                err_d[rr_last_q] = 1'b1;
            end
            if (at_last) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_last_q  <= ID_W'(N_PORTS - 1);
            cnt_q      <= '0;
            m_tdata_q  <= '0;
            m_tid_q    <= '0;
            m_tlast_q  <= 1'b0;
            m_tvalid_q <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            rr_last_q  <= rr_last_d;
            cnt_q      <= cnt_d;
            m_tdata_q  <= m_tdata_d;
            m_tid_q    <= m_tid_d;
            m_tlast_q  <= m_tlast_d;
            m_tvalid_q <= m_tvalid_d;
            err_q      <= err_d;
        end
    end

    assign m_axis.tdata[0]  = m_tdata_q;
    assign m_axis.tid       = m_tid_q;
    assign m_axis.tlast[0]  = m_tlast_q;
    assign m_axis.tvalid[0] = m_tvalid_q;
    assign err_len          = err_q;
    assign busy             = (state_q == PASS);
endmodule
